// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } bcd_state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;
    localparam logic [3:0] BCD_NINE       = 4'h9;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/ready/done handshake plus data bus between a requester and the converter.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
);
    logic                  i_start;
    logic [BIN_W-1:0]      i_bin;
    logic                  o_ready;
    logic                  o_done;
    logic [4*DIGITS-1:0]   o_bcd;
    logic                  o_overflow;

    modport master (
        output i_start, i_bin,
        input  o_ready, o_done, o_bcd, o_overflow
    );

    modport slave (
        input  i_start, i_bin,
        output o_ready, o_done, o_bcd, o_overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    // Conditional add-3 on a single nibble
    always_comb begin
        adj = digit;
        if (digit >= BCD_ADJ_THRESH) begin
            adj = digit + BCD_ADJ_ADD;
        end else begin
            adj = digit;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock, saturating to all nines.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    bin_to_bcd_seq_if.slave      bus
);

    localparam int CNT_W = (BIN_W < 1) ? 1 : $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

    if (BIN_W < 1 || DIGITS < 1) begin : g_param_check
        $error("bin_to_bcd_seq: BIN_W and DIGITS must both be >= 1");
    end

    bcd_state_t             state_r;
    bcd_state_t             next_state_s;
    logic [BIN_W-1:0]       shift_r;
    logic [BCD_W-1:0]       work_r;
    logic                   sticky_r;
    logic [CNT_W-1:0]       count_r;
    logic [BCD_W-1:0]       adj_s;
    logic [BCD_W+BIN_W:0]   shifted_s;
    logic                   ready_r;
    logic                   done_r;
    logic [BCD_W-1:0]       bcd_r;
    logic                   overflow_r;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (work_r[4*g +: 4]),
            .adj   (adj_s[4*g +: 4])
        );
    end

    // The extra top bit catches whatever leaves the most significant digit
    assign shifted_s = {1'b0, adj_s, shift_r} << 1;

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.i_start) begin
                    next_state_s = OP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            OP: begin
                if (count_r == CNT_W'(1)) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = OP;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Conversion datapath: load on accept, one shift-add-3 step per OP cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_r  <= '0;
            work_r   <= '0;
            sticky_r <= 1'b0;
            count_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.i_start) begin
                        shift_r  <= bus.i_bin;
                        work_r   <= '0;
                        sticky_r <= 1'b0;
                        count_r  <= CNT_W'(BIN_W);
                    end
                end
                OP: begin
                    shift_r  <= shifted_s[BIN_W-1:0];
                    work_r   <= shifted_s[BCD_W+BIN_W-1:BIN_W];
                    sticky_r <= sticky_r | shifted_s[BCD_W+BIN_W];
                    count_r  <= count_r - CNT_W'(1);
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Registered outputs; result is published only when a run reaches DONE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            bcd_r      <= '0;
            overflow_r <= 1'b0;
        end else begin
            ready_r <= (next_state_s == IDLE);
            done_r  <= (state_r == DONE);
            if (state_r == DONE) begin
                bcd_r      <= sticky_r ? ALL_NINES : work_r;
                overflow_r <= sticky_r;
            end
        end
    end

    assign bus.o_ready    = ready_r;
    assign bus.o_done     = done_r;
    assign bus.o_bcd      = bcd_r;
    assign bus.o_overflow = overflow_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (4-digit and 3-digit instances).
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.BIN_W(10), .DIGITS(4)) bus4 ();
    bin_to_bcd_seq_if #(.BIN_W(10), .DIGITS(3)) bus3 ();

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) u_dut4 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus4.slave)
    );

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) u_dut3 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus3.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal reference via division, saturating when the value needs more digits
    function automatic logic [15:0] model_bcd(input int v, input int digits);
        logic [15:0] r;
        int p;
        r = 16'h0000;
        p = 1;
        for (int k = 0; k < digits; k++) begin
            r = r | (16'((v / p) % 10) << (4 * k));
            p = p * 10;
        end
        if (v >= p) begin
            r = 16'h0000;
            for (int k = 0; k < digits; k++) r = r | (16'h0009 << (4 * k));
        end
        return r;
    endfunction

    // Entered and left at #1 after a rising edge with the selected DUT idle
    task automatic conv(input bit sel, input int v, input logic [15:0] exp_bcd,
                        input logic exp_ovf, input string tag);
        int   cyc;
        logic d;
        if (sel) begin bus3.i_start = 1'b1; bus3.i_bin = 10'(v); end
        else     begin bus4.i_start = 1'b1; bus4.i_bin = 10'(v); end
        @(posedge clk); #1;
        bus3.i_start = 1'b0; bus4.i_start = 1'b0;
        bus3.i_bin = ~10'(v); bus4.i_bin = ~10'(v);
        chk({tag, "_busy"}, sel ? bus3.o_ready : bus4.o_ready, 32'd0);
        cyc = 0;
        d = 1'b0;
        while (!d && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            d = sel ? bus3.o_done : bus4.o_done;
        end
        chk({tag, "_latency"}, cyc, 32'd11);
        chk({tag, "_bcd"}, sel ? 32'(bus3.o_bcd) : 32'(bus4.o_bcd), 32'(exp_bcd));
        chk({tag, "_ovf"}, sel ? bus3.o_overflow : bus4.o_overflow, 32'(exp_ovf));
        chk({tag, "_ready"}, sel ? bus3.o_ready : bus4.o_ready, 32'd1);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, sel ? bus3.o_done : bus4.o_done, 32'd0);
    endtask

    initial begin
        int dn, rdy, b2b, mis, cyc;
        logic prev;

        bus4.i_start = 1'b0; bus4.i_bin = 10'd0;
        bus3.i_start = 1'b0; bus3.i_bin = 10'd0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus4.o_ready, 32'd1);
        chk("rst_done", bus4.o_done, 32'd0);
        chk("rst_bcd", bus4.o_bcd, 32'd0);
        chk("rst_ovf", bus4.o_overflow, 32'd0);
        chk("rst3_bcd", bus3.o_bcd, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed conversions
        conv(1'b0, 0,    16'h0000, 1'b0, "zero");
        conv(1'b0, 1023, 16'h1023, 1'b0, "max");
        conv(1'b0, 255,  16'h0255, 1'b0, "v255");
        conv(1'b0, 999,  16'h0999, 1'b0, "v999");
        conv(1'b0, 512,  16'h0512, 1'b0, "v512");
        conv(1'b0, 10,   16'h0010, 1'b0, "v10");

        // Three-digit saturation and its boundary
        conv(1'b1, 1000, 16'h0999, 1'b1, "d3_1000");
        conv(1'b1, 42,   16'h0042, 1'b0, "d3_42");
        conv(1'b1, 999,  16'h0999, 1'b0, "d3_999");
        conv(1'b1, 1023, 16'h0999, 1'b1, "d3_1023");

        // Start held high: one conversion every 12 cycles
        bus4.i_start = 1'b1; bus4.i_bin = 10'd5;
        dn = 0; rdy = 0; b2b = 0; mis = 0; prev = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (bus4.o_done) begin
                dn++;
                chk("held_bcd", bus4.o_bcd, 32'h0005);
            end
            if (bus4.o_done && prev) b2b++;
            if (bus4.o_ready) rdy++;
            if (bus4.o_done !== bus4.o_ready) mis++;
            prev = bus4.o_done;
        end
        bus4.i_start = 1'b0;
        chk("held_done_cnt", dn, 32'd2);
        chk("held_ready_cnt", rdy, 32'd2);
        chk("held_done_width", b2b, 32'd0);
        chk("held_ready_align", mis, 32'd0);
        cyc = 0;
        while (!bus4.o_done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("held_tail_done", bus4.o_done, 32'd1);
        @(posedge clk); #1;

        // Reset during OP cycle 4 aborts the run
        bus4.i_start = 1'b1; bus4.i_bin = 10'd999;
        @(posedge clk); #1;
        bus4.i_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", bus4.o_ready, 32'd1);
        chk("abort_done", bus4.o_done, 32'd0);
        chk("abort_bcd", bus4.o_bcd, 32'd0);
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus4.o_done) dn++;
        end
        chk("abort_no_done", dn, 32'd0);
        chk("abort_bcd_hold", bus4.o_bcd, 32'd0);
        conv(1'b0, 999, 16'h0999, 1'b0, "after_abort");

        // Reset and start in the same cycle
        rst = 1'b1; bus4.i_start = 1'b1; bus4.i_bin = 10'd77;
        @(posedge clk); #1;
        rst = 1'b0; bus4.i_start = 1'b0;
        chk("rst_start_ready", bus4.o_ready, 32'd1);
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus4.o_done) dn++;
            if (!bus4.o_ready) dn++;
        end
        chk("rst_start_idle", dn, 32'd0);

        // Exhaustive sweep against the decimal reference
        for (int v = 0; v < 1024; v++) begin
            conv(1'b0, v, model_bcd(v, 4), 1'b0, "sweep");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
